// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor path: state encodings, timing defaults
// and coin counter width, common to coin_filter and the vending FSM.
package coin_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        PRESS   = 4'b0010,
        HOLD    = 4'b0100,
        RELEASE = 4'b1000
    } coin_state_e;

    // 20 ms debounce and 3 s jam time at 50 MHz
    localparam int unsigned CNT_MAX_DEF = 999_999;
    localparam int unsigned JAM_MAX_DEF = 149_999_999;

    localparam int unsigned COIN_CNT_W = 8;
    localparam logic [COIN_CNT_W-1:0] COIN_CNT_SAT = '1;

    // Bits needed to hold max_val without overflow (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/deb_cnt.sv
// Generic saturating debounce counter: synchronous clear, count enable and a
// terminal-count flag that is high while the count equals MAX.
module deb_cnt
    import coin_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned W = cnt_width(MAX);
    localparam logic [W-1:0] MaxV = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != MaxV)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == MaxV);

endmodule

// File: rtl/coin_filter.sv
// Coin-slot sensor conditioner: synchronizes and debounces the active-low sensor,
// emits one po_money pulse per inserted coin, flags jams and counts coins.
module coin_filter
    import coin_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEF,
    parameter int unsigned JAM_MAX = JAM_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_in,
    output logic                  po_money,
    output logic                  po_jam,
    output logic [COIN_CNT_W-1:0] coin_cnt
);

    localparam int unsigned JW = cnt_width(JAM_MAX);
    localparam logic [JW-1:0] JamMaxV = JW'(JAM_MAX);

    logic        sync_q, coin_s;
    coin_state_e state_q, state_d;
    logic        deb_clear, deb_en, deb_tc;
    logic        accept_q, accept_d;
    logic        money_d;
    logic [JW-1:0] jam_q, jam_d;
    logic        po_money_q, po_jam_q, po_jam_d;
    logic [COIN_CNT_W-1:0] coin_cnt_q, coin_cnt_d;

    // Synchronizer resets to the idle (no coin) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            coin_s <= 1'b1;
        end else begin
            sync_q <= coin_in;
            coin_s <= sync_q;
        end
    end

    deb_cnt #(
        .MAX    (CNT_MAX)
    ) u_deb_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (deb_clear),
        .enable (deb_en),
        .tc     (deb_tc)
    );

    always_comb begin
        state_d   = state_q;
        deb_clear = 1'b0;
        deb_en    = 1'b0;
        accept_d  = 1'b0;
        jam_d     = jam_q;
        unique case (state_q)
            IDLE: begin
                deb_clear = 1'b1;
                jam_d     = '0;
                if (!coin_s) state_d = PRESS;
            end
            PRESS: begin
                if (coin_s) begin
                    state_d = IDLE;
                end else if (deb_tc) begin
                    state_d  = HOLD;
                    accept_d = 1'b1;
                end else begin
                    deb_en = 1'b1;
                end
            end
            HOLD: begin
                // Keeps the debounce counter at zero so RELEASE always starts fresh
                deb_clear = 1'b1;
                if (coin_s) begin
                    state_d = RELEASE;
                end else if (jam_q != JamMaxV) begin
                    jam_d = jam_q + JW'(1);
                end
            end
            RELEASE: begin
                if (!coin_s) begin
                    state_d = HOLD;
                end else if (deb_tc) begin
                    state_d = IDLE;
                    jam_d   = '0;
                end else begin
                    deb_en = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_clear = 1'b1;
                jam_d     = '0;
            end
        endcase
    end

    // Acceptance is retimed one cycle; gating on HOLD keeps a corrupt state silent
    always_comb begin
        money_d    = accept_q && (state_q == HOLD);
        coin_cnt_d = coin_cnt_q;
        if (money_d && (coin_cnt_q != COIN_CNT_SAT)) begin
            coin_cnt_d = coin_cnt_q + COIN_CNT_W'(1);
        end
        if (state_d == IDLE) begin
            po_jam_d = 1'b0;
        end else if (jam_d == JamMaxV) begin
            po_jam_d = 1'b1;
        end else begin
            po_jam_d = po_jam_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            accept_q   <= 1'b0;
            jam_q      <= '0;
            po_money_q <= 1'b0;
            po_jam_q   <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            accept_q   <= accept_d;
            jam_q      <= jam_d;
            po_money_q <= money_d;
            po_jam_q   <= po_jam_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    assign po_money = po_money_q;
    assign po_jam   = po_jam_q;
    assign coin_cnt = coin_cnt_q;

endmodule

// File: tb/tb_coin_filter.sv
// Self-checking bench for coin_filter with short debounce/jam times: directed
// vector table, hand-written corner sequences and random stimulus against a model.
module tb_coin_filter;

    localparam int unsigned CNT_MAX = 4;
    localparam int unsigned JAM_MAX = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_in = 1'b1;
    logic       po_money;
    logic       po_jam;
    logic [7:0] coin_cnt;

    coin_filter #(
        .CNT_MAX  (CNT_MAX),
        .JAM_MAX  (JAM_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .coin_in  (coin_in),
        .po_money (po_money),
        .po_jam   (po_jam),
        .coin_cnt (coin_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model in terms of run lengths of the synchronized sensor level:
    // a coin is accepted after CNT_MAX+2 consecutive low samples from idle and
    // released after CNT_MAX+2 consecutive high samples while accepted.
    bit m_sync0, m_sync1, m_prev_s, m_held, m_pend, m_money, m_jam_flag;
    int m_low, m_high, m_jam, m_cnt;

    task automatic model_reset();
        m_sync0 = 1; m_sync1 = 1; m_prev_s = 1;
        m_held = 0; m_pend = 0; m_money = 0; m_jam_flag = 0;
        m_low = 0; m_high = 0; m_jam = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit cin);
        bit s;
        s = m_sync1;
        m_money = m_pend;
        m_pend  = 0;
        if (m_money && m_cnt < 255) m_cnt++;
        if (!m_held) begin
            if (!s) begin
                m_low++;
                if (m_low == CNT_MAX + 2) begin
                    m_held = 1; m_pend = 1; m_low = 0; m_high = 0;
                end
            end else begin
                m_low = 0;
            end
        end else if (s) begin
            m_high++;
            if (m_high == CNT_MAX + 2) begin
                m_held = 0; m_high = 0; m_jam = 0; m_jam_flag = 0;
            end
        end else begin
            // Low sample right after a low sample while held counts as hold time
            if (!m_prev_s && m_jam < JAM_MAX) begin
                m_jam++;
                if (m_jam == JAM_MAX) m_jam_flag = 1;
            end
            m_high = 0;
        end
        m_prev_s = s;
        m_sync1  = m_sync0;
        m_sync0  = cin;
    endtask

    task automatic tick(input logic cin);
        @(negedge clk);
        rst_n   = 1'b1;
        coin_in = cin;
        @(posedge clk);
        model_step(cin);
        #1;
        check("model", {22'd0, po_money, po_jam, coin_cnt},
              {22'd0, m_money, m_jam_flag, m_cnt[7:0]});
        if (po_money) pulses++;
    endtask

    task automatic do_reset(input logic cin);
        @(negedge clk);
        rst_n   = 1'b0;
        coin_in = cin;
        model_reset();
        #1;
        check("rst_async", {22'd0, po_money, po_jam, coin_cnt}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", {22'd0, po_money, po_jam, coin_cnt}, 32'd0);
    endtask

    typedef struct {
        logic       rst;
        logic       cin;
        logic       money;
        logic       jam;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add_vec(input logic rst, input logic cin, input logic money,
                           input logic jam, input logic [7:0] cnt);
        vecs[nvec] = '{rst: rst, cin: cin, money: money, jam: jam, cnt: cnt};
        nvec++;
    endtask

    initial begin
        int first;
        int rise;
        int fall;
        int len;
        logic lvl;

        // Clean coin: low for 15 edges from edge 0, pulse only after edge 8
        add_vec(1, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            add_vec(0, (i < 15) ? 1'b0 : 1'b1, (i == 8) ? 1'b1 : 1'b0, 0,
                    (i >= 8) ? 8'd1 : 8'd0);
        end
        // Short bounce: low 3, high 1, low 2, then high; never accepted
        add_vec(1, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            add_vec(0, (i < 3 || i == 4 || i == 5) ? 1'b0 : 1'b1, 0, 0, 0);
        end

        for (int i = 0; i < nvec; i++) begin
            if (vecs[i].rst) begin
                @(negedge clk);
                rst_n   = 1'b0;
                coin_in = vecs[i].cin;
                model_reset();
                @(posedge clk);
                #1;
            end else begin
                tick(vecs[i].cin);
            end
            check($sformatf("vec%0d", i), {22'd0, po_money, po_jam, coin_cnt},
                  {22'd0, vecs[i].money, vecs[i].jam, vecs[i].cnt});
        end

        // Clean press, then 2-cycle high glitches while releasing
        pulses = 0;
        for (int i = 0; i < 10; i++) tick(1'b0);
        for (int g = 0; g < 2; g++) begin
            tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        end
        for (int i = 0; i < 12; i++) tick(1'b1);
        check("glitch_pulses", pulses, 1);
        check("glitch_cnt", {24'd0, coin_cnt}, 1);

        // Jam: held low 40 cycles
        do_reset(1'b1);
        pulses = 0; rise = -1; fall = -1;
        for (int i = 0; i < 60; i++) begin
            tick((i < 40) ? 1'b0 : 1'b1);
            if (po_jam && rise < 0) rise = i;
            if (!po_jam && rise >= 0 && fall < 0) fall = i;
        end
        check("jam_rise_edge", rise, 27);
        check("jam_fall_edge", fall, 47);
        check("jam_pulses", pulses, 1);

        // Saturation: 260 clean coins
        do_reset(1'b1);
        pulses = 0;
        for (int c = 0; c < 260; c++) begin
            for (int i = 0; i < 8; i++) tick(1'b0);
            for (int i = 0; i < 8; i++) tick(1'b1);
            if (c == 254) check("cnt_at_255", {24'd0, coin_cnt}, 255);
        end
        check("cnt_sat", {24'd0, coin_cnt}, 255);
        check("sat_pulses", pulses, 260);

        // Reset during PRESS with the coin still in the slot
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0);
        do_reset(1'b0);
        pulses = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (po_money && first < 0) first = i;
        end
        check("rst_press_latency", first, CNT_MAX + 4);
        check("rst_press_pulses", pulses, 1);
        for (int i = 0; i < 10; i++) tick(1'b1);

        // Random bursts, some long enough to jam, with occasional resets
        do_reset(1'b1);
        for (int r = 0; r < 400; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(22, 35) : $urandom_range(1, 10);
            if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) tick(lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_filter.md
COIN_FILTER -- requirements
Module: coin_filter

Interface
REQ-001 Parameter CNT_MAX, default 20'd999_999, debounce period in clk cycles (20 ms at 50 MHz), minimum 1.
REQ-002 Parameter JAM_MAX, default 28'd149_999_999, hold time in clk cycles before a coin is flagged jammed (3 s), minimum CNT_MAX+1.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 coin_in  input  1  raw coin-slot sensor, asynchronous to clk, active-low (0 = coin in slot), bouncy on both edges.
REQ-006 po_money  output  1  one-cycle pulse per accepted coin; drives pi_money of the downstream vending FSM.
REQ-007 po_jam  output  1  level, high while a coin is held beyond JAM_MAX.
REQ-008 coin_cnt  output  8  saturating count of accepted coins since reset.

Function
REQ-009 coin_in SHALL pass through a 2-flop synchronizer before any use; the second flop output is coin_s.
REQ-010 FSM states SHALL be IDLE, PRESS, HOLD, RELEASE, one-hot encoded, registered in a single always block.
REQ-011 IDLE: coin_s==0 -> PRESS with debounce counter cleared; otherwise stay.
REQ-012 PRESS: counter increments each cycle coin_s==0; coin_s==1 at any point -> IDLE, no pulse; counter==CNT_MAX with coin_s==0 -> HOLD.
REQ-013 po_money SHALL be registered high for exactly the one cycle following the PRESS->HOLD edge, low in every other cycle.
REQ-014 Latency: po_money asserts CNT_MAX+4 clock edges after the first edge at which coin_in is sampled low (steady input).
REQ-015 HOLD: jam counter increments each cycle coin_s==0, saturating at JAM_MAX; coin_s==1 -> RELEASE with debounce counter cleared.
REQ-016 po_jam SHALL go high on the edge the jam counter reaches JAM_MAX and stay high until the FSM next enters IDLE.
REQ-017 RELEASE: counter increments each cycle coin_s==1; coin_s==0 -> HOLD (jam counter not cleared); counter==CNT_MAX with coin_s==1 -> IDLE, jam counter cleared.
REQ-018 Only one po_money pulse SHALL be produced per IDLE->...->IDLE cycle, regardless of bounce count.
REQ-019 coin_cnt SHALL increment on the same edge po_money rises, saturate at 8'd255, and never wrap.
REQ-020 Illegal state encodings SHALL return to IDLE on the next edge with po_money low.
REQ-021 Counters SHALL be sized to hold their parameter value with no overflow.

Reset
REQ-022 While rst_n==0: state=IDLE, both counters=0, synchronizer flops=1 (idle level), po_money=0, po_jam=0, coin_cnt=0.
REQ-023 Reset asserted mid-PRESS or mid-HOLD SHALL abort with no pulse; after release, a still-low coin_in is re-debounced from IDLE and produces one pulse.

Structure
REQ-024 State encodings, CNT_MAX/JAM_MAX defaults and coin_cnt width SHALL live in a shared package (coin_pkg) also used by the vending FSM.
REQ-025 The generic debounce counter (clear, enable, terminal-count flag) SHALL be one sub-module, deb_cnt, instantiated for the shared debounce counter; jam counter inline.
REQ-026 Target size 120-250 lines RTL; no latches, no combinational outputs.

Verification (CNT_MAX=4, JAM_MAX=20)
REQ-027 coin_in low from edge 0, held 15 cycles, then high -> po_money high only in cycle after edge 8, coin_cnt=1, po_jam=0.
REQ-028 coin_in low 3 cycles, high 1, low 2, high -> no po_money, coin_cnt=0, FSM back in IDLE.
REQ-029 clean press with 2-cycle high glitches during release -> exactly one po_money pulse, coin_cnt=1.
REQ-030 coin_in held low 40 cycles -> one po_money, po_jam rises when jam counter hits 20, falls the edge FSM re-enters IDLE.
REQ-031 260 clean coins -> coin_cnt reads 255 after the 255th and stays 255; 260 po_money pulses observed.
REQ-032 rst_n pulsed low during PRESS with coin_in held low -> all outputs 0 during reset; exactly one pulse CNT_MAX+4 edges after the first post-reset edge.
